a2d_resp: RTL and testbench

Synthesizable SPI responder modelling the 8-channel, 12-bit A2D converter that sits on the far end of the A2D SPI link. It receives 16-bit commands from the SPI master, decodes the channel in cmd[13:11], captures that channel's sample from a parallel sample bus, and returns it on the next transaction, so results are one transaction deep. It is used as the converter model in system-level benches and as a stand-in converter on FPGA builds. All logic runs on clk, with oversampled SPI pins.

---
 rtl/a2d_resp_if.sv | 17 +
 rtl/a2d_resp.sv | 149 ++++++++++++++
 tb/tb_a2d_resp.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/a2d_resp_if.sv
// a2d_resp_if: SPI pin bundle for the A2D link.
//   SS_n : slave select, active low (master -> responder)
//   SCLK : serial clock, idles high (master -> responder)
//   MOSI : command data (master -> responder)
//   MISO : response data (responder -> master)
// Handshake: there is no valid/ready pair on this link. A frame is framed
// by SS_n low; the master changes MOSI after SCLK falls, and both sides
// sample on the SCLK rise. The responder oversamples every pin on its own clk.
interface a2d_resp_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, output SCLK, output MOSI, input MISO);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/a2d_resp.sv
// a2d_resp: SPI responder modelling an 8-channel, 12-bit A2D converter.
// A 16-bit command selects a channel in cmd[13:11]; the sample on that
// channel is captured when the frame completes and shifted out on the next
// frame, so results are one transaction deep.
//
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   spi        : a2d_resp_if.slave (SS_n, SCLK, MOSI in; MISO out)
//   ch_vals    : eight 12-bit samples, channel n = ch_vals[12n+11:12n]
//   chnnl      : channel decoded from the last complete command
//   cnv_done   : one-clk pulse when a complete command is accepted
//   dbg_state  : current FSM state (0 = IDLE, 1 = SHIFT)
//
// Build option: define A2D_INV_DATA_EN to send the 12 data bits inverted.
module a2d_resp #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  a2d_resp_if.slave   spi,
  input  logic [95:0] ch_vals,
  output logic [2:0]  chnnl,
  output logic        cnv_done,
  output logic        dbg_state
);

  localparam int NE = SYNC_STAGES + 1;  // sync chain plus edge-detect flop

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  // Pin synchronizers; index 0 is the first stage.
  logic [NE-1:0]          ss_q, ss_d;
  logic [NE-1:0]          sclk_q, sclk_d;
  logic [SYNC_STAGES-1:0] mosi_q, mosi_d;

  state_e      state_q, state_d;
  logic [15:0] tx_q, tx_d;
  logic [15:0] rx_q, rx_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [11:0] held_q, held_d;
  logic [2:0]  chnnl_q, chnnl_d;
  logic        cnv_done_q, cnv_done_d;

  logic        ss_fall, ss_rise, sclk_fall, sclk_rise, mosi_sync;
  logic [11:0] tx_data;
  logic [11:0] ch_arr [8];
  logic        unused_rx_msb;

  always_comb begin
    ss_d   = {ss_q[NE-2:0], spi.SS_n};
    sclk_d = {sclk_q[NE-2:0], spi.SCLK};
    mosi_d = {mosi_q[SYNC_STAGES-2:0], spi.MOSI};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_q   <= '1;
      sclk_q <= '1;
      mosi_q <= '0;
    end else begin
      ss_q   <= ss_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
    end
  end

  // Edge detect compares the synchronized value with one flop later.
  assign ss_fall   =  ss_q[NE-1]   & ~ss_q[NE-2];
  assign ss_rise   = ~ss_q[NE-1]   &  ss_q[NE-2];
  assign sclk_fall =  sclk_q[NE-1] & ~sclk_q[NE-2];
  assign sclk_rise = ~sclk_q[NE-1] &  sclk_q[NE-2];
  assign mosi_sync =  mosi_q[SYNC_STAGES-1];

  always_comb begin
    for (int i = 0; i < 8; i++) ch_arr[i] = ch_vals[i*12 +: 12];
  end

`ifdef A2D_INV_DATA_EN
  assign tx_data = ~held_q;
`else
  assign tx_data = held_q;
`endif

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    cnt_d      = cnt_q;
    held_d     = held_q;
    chnnl_d    = chnnl_q;
    cnv_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          tx_d    = {4'h0, tx_data};
          rx_d    = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // SS_n rise takes priority; a coincident SCLK edge is dropped.
        if (ss_rise) begin
          if (cnt_q == 5'd16) begin
            chnnl_d    = rx_q[13:11];
            held_d     = ch_arr[rx_q[13:11]];
            cnv_done_d = 1'b1;
          end
          state_d = IDLE;
        end else if (sclk_rise) begin
          rx_d = {rx_q[14:0], mosi_sync};
          if (cnt_q != 5'd31) cnt_d = cnt_q + 5'd1;
        end else if (sclk_fall) begin
          // The fall that precedes the first rise must not shift out bit 15.
          if (cnt_q != 5'd0) tx_d = {tx_q[14:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tx_q       <= '0;
      rx_q       <= '0;
      cnt_q      <= '0;
      held_q     <= '0;
      chnnl_q    <= '0;
      cnv_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      cnt_q      <= cnt_d;
      held_q     <= held_d;
      chnnl_q    <= chnnl_d;
      cnv_done_q <= cnv_done_d;
    end
  end

  assign unused_rx_msb = rx_q[15];

  assign spi.MISO  = (state_q == SHIFT) & tx_q[15];
  assign chnnl     = chnnl_q;
  assign cnv_done  = cnv_done_q;
  assign dbg_state = (state_q == SHIFT);

endmodule

// File: tb/tb_a2d_resp.sv
module tb_a2d_resp;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [95:0] ch_vals;
  logic [2:0]  chnnl;
  logic        cnv_done;
  logic        dbg_state;

  a2d_resp_if spi();

  a2d_resp #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi       (spi.slave),
    .ch_vals   (ch_vals),
    .chnnl     (chnnl),
    .cnv_done  (cnv_done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [15:0] exp_q[$];
  logic [11:0] model_held;
  logic [2:0]  model_chnnl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [15:0] exp_word(input logic [11:0] h);
`ifdef A2D_INV_DATA_EN
    return {4'h0, ~h};
`else
    return {4'h0, h};
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_ch(input int ch, input logic [11:0] v);
    ch_vals[ch*12 +: 12] = v;
  endtask

  // Shift n bits of data (MSB first); MISO sampled just before each rise.
  task automatic shift_bits(input logic [15:0] data, input int n, inout logic [15:0] r);
    logic [15:0] c;
    c = data;
    for (int i = 0; i < n; i++) begin
      spi.SCLK = 1'b0;
      spi.MOSI = c[15];
      c = c << 1;
      repeat (6) @(negedge clk);
      r = {r[14:0], spi.MISO};
      spi.SCLK = 1'b1;
      repeat (6) @(negedge clk);
    end
  endtask

  // Raise SS_n and watch cnv_done for a bounded window.
  task automatic end_frame(input bit scramble, output int lat, output int pulses);
    lat = 0;
    pulses = 0;
    spi.SS_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (cnv_done === 1'b1) begin
        pulses++;
        if (lat == 0) lat = i;
      end
      if (scramble && lat != 0 && i == lat + 1) ch_vals = {$urandom, $urandom, $urandom};
    end
  endtask

  task automatic frame(input logic [15:0] cmd, input int nbits, input bit scramble,
                       output logic [15:0] rd, output int lat, output int pulses,
                       output logic [11:0] snap);
    logic [15:0] r;
    r = '0;
    @(negedge clk);
    spi.SS_n = 1'b0;
    repeat (6) @(negedge clk);
    shift_bits(cmd, (nbits > 16) ? 16 : nbits, r);
    if (nbits > 16) shift_bits(16'h0000, nbits - 16, r);
    snap = ch_vals[int'(cmd[13:11])*12 +: 12];
    end_frame(scramble, lat, pulses);
    rd = r;
  endtask

  task automatic full_frame(input logic [15:0] cmd, input bit scramble);
    logic [15:0] rd;
    logic [11:0] snap;
    int lat, pulses;
    exp_q.push_back(exp_word(model_held));
    frame(cmd, 16, scramble, rd, lat, pulses, snap);
    check("rd_data", rd, exp_q.pop_front());
    check("cnv_done_lat", lat, 3);
    check("cnv_done_width", pulses, 1);
    check("chnnl", chnnl, cmd[13:11]);
    check("idle_after", dbg_state, 0);
    model_held  = snap;
    model_chnnl = cmd[13:11];
  endtask

  task automatic aborted_frame(input logic [15:0] cmd, input int nbits);
    logic [15:0] rd;
    logic [11:0] snap;
    int lat, pulses;
    frame(cmd, nbits, 1'b0, rd, lat, pulses, snap);
    check("abort_no_done", pulses, 0);
    check("abort_chnnl", chnnl, model_chnnl);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] r;
    int lat, pulses;
    rst_n = 1'b0;
    spi.SS_n = 1'b1;
    spi.SCLK = 1'b1;
    spi.MOSI = 1'b0;
    ch_vals = '0;
    model_held = '0;
    model_chnnl = '0;
    repeat (3) @(negedge clk);
    check("rst_miso", spi.MISO, 0);
    check("rst_cnv_done", cnv_done, 0);
    check("rst_chnnl", chnnl, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Capture and return, then back-to-back extremes.
    set_ch(3, 12'hA5C);
    full_frame(16'h1800, 1'b0);
    set_ch(7, 12'hFFF);
    full_frame(16'h3800, 1'b0);
    set_ch(0, 12'h000);
    full_frame(16'h0000, 1'b0);
    set_ch(2, 12'h123);
    full_frame(16'h1000, 1'b0);

    // Aborted (short) and overrun (17-bit) frames leave state untouched.
    set_ch(4, 12'h9B1);
    aborted_frame(16'h2000, 8);
    aborted_frame(16'h3800, 17);
    // Junk in the other command bits; channel 4 selected.
    full_frame(16'hE7A5, 1'b0);

    // Reset in the middle of a channel-5 command.
    set_ch(5, 12'h5A5);
    r = '0;
    @(negedge clk);
    spi.SS_n = 1'b0;
    repeat (6) @(negedge clk);
    shift_bits(16'h2800, 5, r);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_state", dbg_state, 0);
    check("midrst_chnnl", chnnl, 0);
    check("midrst_miso", spi.MISO, 0);
    rst_n = 1'b1;
    model_held = '0;
    model_chnnl = '0;
    shift_bits(16'h0000, 11, r);
    end_frame(1'b0, lat, pulses);
    check("midrst_no_done", pulses, 0);
    full_frame(16'h0800, 1'b0);

    // Capture isolation: ch_vals scrambled one clk after cnv_done.
    set_ch(6, 12'h3C7);
    full_frame(16'h3000, 1'b1);
    full_frame(16'h0000, 1'b0);

    // Random commands and samples.
    for (int k = 0; k < 6; k++) begin
      ch_vals = {$urandom, $urandom, $urandom};
      full_frame(16'($urandom_range(0, 16'hFFFF)), 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
